// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding, port ids and
// the address-legality check used at grant time.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned MEM_WORDS_DEFAULT = 1024;

  // Misaligned or past-the-end byte addresses are rejected.
  function automatic logic addr_bad(input logic [31:0] addr, input int unsigned words);
    return (addr[1:0] != 2'b00) || (addr >= 32'(words * 4));
  endfunction

endpackage

// File: rtl/arb_prio.sv
// Winner select between fetch and data ports, with a saturating starvation
// counter that hands the grant to fetch after STARVE_LIMIT consecutive losses.
module arb_prio
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic grant_vld,
  output logic grant_port
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            starved;

  assign starved = (cnt_q == CntW'(STARVE_LIMIT));

  always_comb begin
    grant_vld  = i_req | d_req;
    grant_port = (d_req && !(i_req && starved)) ? PORT_D : PORT_I;
    cnt_d      = cnt_q;
    // Only arbitration cycles move the counter; ACCESS/DONE leave it alone.
    if (arb_en) begin
      if (!i_req || (grant_port == PORT_I)) begin
        cnt_d = '0;
      end else if (!starved) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single unified memory: IDLE arbitrates,
// ACCESS drives memory for one cycle, DONE acks the winner for one cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = MEM_WORDS_DEFAULT,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  state_e      state_q, state_d;
  logic        port_q;
  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        grant_vld;
  logic        grant_port;
  logic        arb_en;
  logic [31:0] sel_addr;

  assign arb_en   = (state_q == StIdle);
  assign sel_addr = (grant_port == PORT_D) ? d_addr : i_addr;

  arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb_prio (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .i_req     (i_req),
    .d_req     (d_req),
    .grant_vld (grant_vld),
    .grant_port(grant_port)
  );

  // Outputs decode from registered state only, so reset clears them without a clock.
  always_comb begin
    state_d  = state_q;
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    i_ack    = 1'b0;
    i_rdata  = '0;
    i_err    = 1'b0;
    d_ack    = 1'b0;
    d_rdata  = '0;
    d_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_vld) state_d = StAccess;
      end
      StAccess: begin
        mem_addr = addr_q;
        mem_wd   = wdata_q;
        mem_we   = we_q & ~err_q;
        state_d  = StDone;
      end
      StDone: begin
        if (port_q == PORT_D) begin
          d_ack   = 1'b1;
          d_rdata = rdata_q;
          d_err   = err_q;
        end else begin
          i_ack   = 1'b1;
          i_rdata = rdata_q;
          i_err   = err_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      port_q  <= PORT_I;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state_q == StIdle) begin
      if (grant_vld) begin
        port_q  <= grant_port;
        addr_q  <= sel_addr;
        we_q    <= (grant_port == PORT_D) ? d_we : 1'b0;
        wdata_q <= (grant_port == PORT_D) ? d_wdata : '0;
        err_q   <= addr_bad(sel_addr, MEM_WORDS);
      end
    end else if (state_q == StAccess) begin
      // Stores and faulting accesses return zero data.
      rdata_q <= (we_q || err_q) ? '0 : mem_rd;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural unified memory.
module tb_mem_arbiter;

  localparam int unsigned MemWords = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_ack, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_ack, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we;

  logic [31:0] mem [MemWords];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[11:2]] <= mem_wd;
  end
  assign mem_rd = mem[mem_addr[11:2]];

  mem_arbiter #(
    .MEM_WORDS   (MemWords),
    .STARVE_LIMIT(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_ack   (i_ack),
    .i_rdata (i_rdata),
    .i_err   (i_err),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_ack   (d_ack),
    .d_rdata (d_rdata),
    .d_err   (d_err),
    .mem_addr(mem_addr),
    .mem_wd  (mem_wd),
    .mem_we  (mem_we),
    .mem_rd  (mem_rd)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data transaction from IDLE; exact N+1 / N+2 timing is checked.
  task automatic d_xact(input vec_t v);
    d_req   = 1'b1;
    d_we    = v.we;
    d_addr  = v.addr;
    d_wdata = v.wdata;
    tick();
    chk({v.name, " access mem_addr"}, mem_addr, v.addr);
    chk({v.name, " access mem_we"}, {31'd0, mem_we}, {31'd0, v.we & ~v.exp_err});
    chk({v.name, " no early ack"}, {30'd0, d_ack, i_ack}, 32'd0);
    // Changes after grant must not leak into the access.
    d_addr  = 32'hFFFF_FFFC;
    d_wdata = 32'hFFFF_FFFF;
    if (v.we && !v.exp_err)
      chk({v.name, " access mem_wd"}, mem_wd, v.wdata);
    tick();
    chk({v.name, " ack"}, {30'd0, d_ack, i_ack}, 32'd2);
    chk({v.name, " rdata"}, d_rdata, v.exp_rdata);
    chk({v.name, " err"}, {31'd0, d_err}, {31'd0, v.exp_err});
    chk({v.name, " done mem idle"}, {mem_addr[30:0], mem_we}, 32'd0);
    d_req = 1'b0;
    tick();
    chk({v.name, " ack pulse ends"}, {d_ack, d_err, d_rdata[29:0]}, 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    string seq;
    string exp_seq;
    int    n;
    int    cyc;
    int    grants;
    logic  got;

    for (int i = 0; i < MemWords; i++) mem[i] = 32'h1000_0000 + i;
    mem[0]    = 32'hA5A5_0000;
    mem[60]   = 32'h2042_0003;
    mem[61]   = 32'h1357_9BDF;
    mem[1023] = 32'h0BAD_F00D;

    vecs[0] = '{"load_f0",    1'b0, 32'h0000_00F0, 32'h0,         32'h2042_0003, 1'b0};
    vecs[1] = '{"store_10",   1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[2] = '{"load_10",    1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{"st_misal",   1'b1, 32'h0000_0002, 32'h7777_7777, 32'h0,         1'b1};
    vecs[4] = '{"ld_oob",     1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
    vecs[5] = '{"ld_misal",   1'b0, 32'h0000_0002, 32'h0,         32'h0,         1'b1};
    vecs[6] = '{"load_0",     1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_0000, 1'b0};
    vecs[7] = '{"load_last",  1'b0, 32'h0000_0FFC, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[8] = '{"store_last", 1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'h0,         1'b0};

    rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    #12;
    chk("reset acks", {29'd0, i_ack, d_ack, mem_we}, 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset rdata", i_rdata | d_rdata | mem_wd, 32'd0);
    tick();
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) d_xact(vecs[k]);
    chk("store_last memory", mem[1023], 32'h1234_5678);
    chk("st_misal memory word0", mem[0], 32'hA5A5_0000);

    // Contention: both held, expect D,D,D,D,I twice.
    i_req = 1'b1; i_addr = 32'h0000_00F0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0010;
    seq = ""; exp_seq = "DDDDIDDDDI"; grants = 0;
    for (int c = 0; c < 40 && grants < 10; c++) begin
      tick();
      if (d_ack && i_ack) chk("contention dual ack", 32'd1, 32'd0);
      if (d_ack) begin seq = {seq, "D"}; grants++; end
      if (i_ack) begin
        seq = {seq, "I"}; grants++;
        chk("contention i_rdata", i_rdata, 32'h2042_0003);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (seq != exp_seq) begin
      errors++;
      $display("FAIL contention order: got %s expected %s", seq, exp_seq);
    end
    tick();

    // Back-to-back fetch with a new address presented during the ack.
    i_req = 1'b1; i_addr = 32'h0000_00F0;
    n = 0; got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin tick(); n++; got = i_ack; end
    chk("fetch1 latency", n, 32'd2);
    chk("fetch1 rdata", i_rdata, 32'h2042_0003);
    i_addr = 32'h0000_00F4;
    n = 0; got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin tick(); n++; got = i_ack; end
    chk("fetch2 spacing", n, 32'd3);
    chk("fetch2 rdata", i_rdata, 32'h1357_9BDF);
    chk("fetch2 err", {31'd0, i_err}, 32'd0);
    i_req = 1'b0;
    tick();

    // Reset in the ACCESS cycle of a store.
    mem[8] = 32'h1111_1111;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0020; d_wdata = 32'hCAFE_F00D;
    tick();
    chk("abort pre mem_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort mem_we async", {31'd0, mem_we}, 32'd0);
    chk("abort mem_addr async", mem_addr, 32'd0);
    d_req = 1'b0;
    tick();
    chk("abort word unchanged", mem[8], 32'h1111_1111);
    rst_n = 1'b1;
    cyc = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (d_ack || i_ack) cyc++;
    end
    chk("abort no ack", cyc, 32'd0);
    d_xact('{"post_reset_ld", 1'b0, 32'h0000_0020, 32'h0, 32'h1111_1111, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
